mxint8_quantize_stream: RTL and testbench
=========================================

// Module: mxint8_quantize_stream
// PURPOSE
//  Float32-to-MXINT8 block encoder; the inverse of the MXINT8 summing/decode path.
//  Accepts a stream of float32 values one per cycle and buffers BLOCK_SIZE of them.
//  Derives the shared 8-bit scale and quantizes each value to an int8 element (1.6 fixed point).
//  Presents the whole block (scale + element array) on a valid/ready output for the MX ALU datapath.
// PARAMETERS
//  BLOCK_SIZE     32   elements per MX block (default from `BLOCK_SIZE)
//  CNT_WIDTH      5    element index width, $clog2(BLOCK_SIZE)
// PORTS
//  i_clk              in   1         clock
//  i_rst              in   1         reset, asynchronous, active-high
//  i_float32          in   32        IEEE-754 binary32 input element
//  i_valid            in   1         i_float32 valid
//  o_ready            out  1         encoder accepts i_float32 this cycle
//  o_scale            out  8         shared scale, E8M0 (biased 127), 8'hFF = NaN block
//  o_mxint8_elements  out  8 x BLOCK_SIZE  quantized two's-complement elements
//  o_valid            out  1         block outputs valid
//  i_ready            in   1         consumer takes block
//  o_saturated        out  1         >=1 element clamped to +/-127 in this block
//  o_is_nan           out  1         block contained NaN or Inf
// BEHAVIOUR
//  Reset: state COLLECT, idx=0, max_exp=0, nan=0; o_valid=0, o_ready=1, o_scale=0,
//   elements=0, o_saturated=0, o_is_nan=0. No transfer counts while i_rst high.
//  FSM COLLECT -> QUANT -> OUT -> COLLECT.
//   COLLECT: o_ready=1; on i_valid&o_ready store word in buf[idx], idx++.
//    Running max over biased exponent e=i_float32[30:23]; e==8'hFF sets sticky nan.
//    On accept with idx==BLOCK_SIZE-1: idx<=0, go QUANT.
//   QUANT: o_ready=0; one element per cycle, idx 0..BLOCK_SIZE-1, result to element reg.
//    After idx==BLOCK_SIZE-1 go OUT. o_valid rises BLOCK_SIZE+1 edges after the last accept edge.
//   OUT: o_valid=1; scale, elements and flags held stable until i_valid... i_ready sampled high.
//    On o_valid&i_ready: go COLLECT, clear max_exp/nan/saturated, idx=0.
//    No input is accepted in the same cycle as the output handshake.
//  Scale: nan ? 8'hFF : max_exp. All-zero/subnormal block -> scale 0.
//  Element quantize (x in buf, e=x[30:23], s=x[31], m={1,x[22:0]} 24b):
//   e==0 (zero/subnormal, flushed) -> 0.
//   d = 17 + (scale - e); d>=25 -> q=0; else q=(m>>d)+m[d-1] (round half away from 0).
//   q>127 -> q=127, set o_saturated. Element = s ? -q : q.
//   8'h80 is never produced (reserved "unused" code).
//   nan block: all elements 0, o_saturated=0.
//  Back-pressure: i_ready low in OUT stalls indefinitely; o_ready stays 0 (single block buffer).
//  Reset mid-operation: partial block discarded, o_valid drops immediately (async), restart at idx 0.
// STRUCTURE
//  Shared include/package: FLOAT32 sign/exponent/mantissa field ranges, MXINT8_ELEMENT_WIDTH,
//   SCALE_WIDTH, BLOCK_SIZE, SCALE_NAN=8'hFF, MXINT8_UNUSED=8'h80, MXINT8_MAX=127, FSM state encoding.
//  Sub-module mxint8_quant_elem: combinational float32+scale -> int8 + sat flag,
//   instantiated once and time-multiplexed over idx in QUANT.
//  Top: FSM, idx counter, max-exponent tracker, float buffer, element/flag registers.
// TESTING
//  1. 32x 0x3F800000 (1.0) -> o_scale=8'h7F, all elements 8'h40, sat=0, nan=0;
//     o_valid high exactly BLOCK_SIZE+1 edges after last accept.
//  2. e0=0x40000000 (2.0), e1=0x3F400000 (0.75), rest 0 -> scale 8'h80, e0=8'h40, e1=8'h18, rest 8'h00.
//  3. e0=0x3FFFFFFF, e1=0xBF800000 (-1.0), rest 0 -> scale 8'h7F, e0=8'h7F, sat=1, e1=8'hC0.
//  4. e5=0x7FC00000, others 1.0 -> scale 8'hFF, nan=1, all elements 0.
//  5. all 0x00000000 / 0x00000001 mix -> scale 8'h00, all elements 0; i_valid gaps of 3 cycles
//     do not disturb idx.
//  6. hold i_ready=0 for 5 cycles in OUT -> outputs stable, o_ready=0; then assert i_rst mid-COLLECT
//     after 10 accepts -> next 32 accepts form a clean block per test 1.

Source files
------------

// File: rtl/mxint8_quantize_stream_pkg.sv
// Shared constants for the float32 -> MXINT8 block encoder: field ranges, code points, FSM encoding.
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif

package mxint8_quantize_stream_pkg;

    localparam int unsigned FLOAT32_WIDTH        = 32;
    localparam int unsigned FLOAT32_SIGN_BIT     = 31;
    localparam int unsigned FLOAT32_EXP_MSB      = 30;
    localparam int unsigned FLOAT32_EXP_LSB      = 23;
    localparam int unsigned FLOAT32_MANT_MSB     = 22;
    localparam int unsigned FLOAT32_MANT_WIDTH   = 24;

    localparam int unsigned MXINT8_ELEMENT_WIDTH = 8;
    localparam int unsigned SCALE_WIDTH          = 8;
    localparam int unsigned MX_BLOCK_SIZE        = `BLOCK_SIZE;

    localparam logic [SCALE_WIDTH-1:0]          SCALE_NAN     = 8'hFF;
    localparam logic [MXINT8_ELEMENT_WIDTH-1:0] MXINT8_UNUSED = 8'h80;
    localparam logic [MXINT8_ELEMENT_WIDTH-1:0] MXINT8_MAX    = 8'd127;

    // Mantissa alignment: 1.6 fixed point puts the hidden bit 17 positions above the int8 LSB.
    localparam int unsigned QUANT_BASE_SHIFT     = 17;
    localparam int unsigned QUANT_ZERO_SHIFT     = 25;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_QUANT   = 2'd1;
    localparam logic [1:0] ST_OUT     = 2'd2;

endpackage

// File: rtl/mxint8_quant_elem.sv
// Combinational quantizer: one float32 against the shared block scale -> int8 element + clamp flag.
module mxint8_quant_elem
    import mxint8_quantize_stream_pkg::*;
(
    input  logic [FLOAT32_WIDTH-1:0]        i_float32,
    input  logic [SCALE_WIDTH-1:0]          i_scale,
    input  logic                            i_nan,
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_element_c,
    output logic                            o_saturated_c
);

    logic                            w_sign;
    logic [7:0]                      w_exp;
    logic [FLOAT32_MANT_WIDTH-1:0]   w_mant;
    logic [8:0]                      w_d;
    logic [7:0]                      w_pre;
    logic [MXINT8_ELEMENT_WIDTH-1:0] w_q;
    logic [MXINT8_ELEMENT_WIDTH-1:0] w_mag;

    always_comb begin
        w_sign        = i_float32[FLOAT32_SIGN_BIT];
        w_exp         = i_float32[FLOAT32_EXP_MSB:FLOAT32_EXP_LSB];
        w_mant        = {1'b1, i_float32[FLOAT32_MANT_MSB:0]};
        w_d           = 9'(QUANT_BASE_SHIFT) + 9'(i_scale) - 9'(w_exp);
        // Shift by d-1 so the rounding bit lands in bit 0; d in 17..24 keeps this within 8 bits.
        w_pre         = 8'(w_mant >> (w_d[4:0] - 5'd1));
        w_q           = 8'(w_pre[7:1]) + 8'(w_pre[0]);
        w_mag         = '0;
        o_saturated_c = 1'b0;
        o_element_c   = '0;
        if (!i_nan && (w_exp != 8'd0) && (w_exp <= i_scale) && (w_d < 9'(QUANT_ZERO_SHIFT))) begin
            if (w_q > MXINT8_MAX) begin
                w_mag         = MXINT8_MAX;
                o_saturated_c = 1'b1;
            end else begin
                w_mag = w_q;
            end
            o_element_c = w_sign ? 8'(8'd0 - w_mag) : w_mag;
        end
    end

endmodule

// File: rtl/mxint8_quantize_stream.sv
// Float32 stream -> MXINT8 block encoder: buffers a block, derives the shared scale, quantizes serially.
module mxint8_quantize_stream
    import mxint8_quantize_stream_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = MX_BLOCK_SIZE,
    parameter int unsigned CNT_WIDTH  = $clog2(BLOCK_SIZE)
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic [FLOAT32_WIDTH-1:0]                        i_float32,
    input  logic                                            i_valid,
    output logic                                            o_ready,
    output logic [SCALE_WIDTH-1:0]                          o_scale,
    output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements,
    output logic                                            o_valid,
    input  logic                                            i_ready,
    output logic                                            o_saturated,
    output logic                                            o_is_nan
);

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_next;
    logic                            w_ready_next;
    logic                            w_valid_next;
    logic                            w_accept;
    logic                            w_handshake;
    logic                            w_last;
    logic [CNT_WIDTH-1:0]            r_idx;
    logic [7:0]                      r_max_exp;
    logic                            r_nan;
    logic [FLOAT32_WIDTH-1:0]        r_buf [BLOCK_SIZE];
    logic [7:0]                      w_exp_in;
    logic [SCALE_WIDTH-1:0]          w_scale;
    logic [MXINT8_ELEMENT_WIDTH-1:0] w_elem;
    logic                            w_elem_sat;

    assign w_last   = (r_idx == CNT_WIDTH'(BLOCK_SIZE - 1));
    assign w_exp_in = i_float32[FLOAT32_EXP_MSB:FLOAT32_EXP_LSB];
    assign w_scale  = r_nan ? SCALE_NAN : r_max_exp;

    mxint8_quant_elem u_quant_elem (
        .i_float32     (r_buf[r_idx]),
        .i_scale       (w_scale),
        .i_nan         (r_nan),
        .o_element_c   (w_elem),
        .o_saturated_c (w_elem_sat)
    );

    // State register; o_ready/o_valid registered alongside it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_COLLECT;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            o_ready <= w_ready_next;
            o_valid <= w_valid_next;
        end
    end

    // Next state; o_valid lags entry into OUT by one cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_accept = i_valid & o_ready;
                if (w_accept && w_last) w_state_next = ST_QUANT;
            end
            ST_QUANT: begin
                if (w_last) w_state_next = ST_OUT;
            end
            ST_OUT: begin
                w_handshake = o_valid & i_ready;
                if (w_handshake) w_state_next = ST_COLLECT;
            end
            default: w_state_next = ST_COLLECT;
        endcase
        w_ready_next = (w_state_next == ST_COLLECT);
        w_valid_next = (r_state == ST_OUT) && !w_handshake;
    end

    // Input word store; always written before it is read, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_accept) r_buf[r_idx] <= i_float32;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx             <= '0;
            r_max_exp         <= '0;
            r_nan             <= 1'b0;
            o_scale           <= '0;
            o_mxint8_elements <= '0;
            o_saturated       <= 1'b0;
            o_is_nan          <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_idx <= w_last ? '0 : CNT_WIDTH'(r_idx + 1'b1);
                        if (w_exp_in > r_max_exp) r_max_exp <= w_exp_in;
                        if (w_exp_in == 8'hFF)    r_nan     <= 1'b1;
                    end
                end
                ST_QUANT: begin
                    r_idx                    <= w_last ? '0 : CNT_WIDTH'(r_idx + 1'b1);
                    o_mxint8_elements[r_idx] <= w_elem;
                    o_scale                  <= w_scale;
                    o_is_nan                 <= r_nan;
                    if (w_elem_sat) o_saturated <= 1'b1;
                end
                ST_OUT: begin
                    if (w_handshake) begin
                        r_idx       <= '0;
                        r_max_exp   <= '0;
                        r_nan       <= 1'b0;
                        o_saturated <= 1'b0;
                        o_is_nan    <= 1'b0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mxint8_quantize_stream.sv
// Directed bench for mxint8_quantize_stream with hand-computed expected blocks.
module tb_mxint8_quantize_stream;

    localparam int unsigned BS = 32;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [31:0]          i_float32;
    logic                 i_valid;
    logic                 o_ready;
    logic [7:0]           o_scale;
    logic [BS-1:0][7:0]   o_mxint8_elements;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_saturated;
    logic                 o_is_nan;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    logic [31:0]          blk    [BS];
    logic [7:0]           exp_el [BS];
    int                   edges;

    always #5 i_clk = ~i_clk;

    mxint8_quantize_stream #(.BLOCK_SIZE(BS), .CNT_WIDTH(5)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_float32         (i_float32),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .o_scale           (o_scale),
        .o_mxint8_elements (o_mxint8_elements),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_saturated       (o_saturated),
        .o_is_nan          (o_is_nan)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < BS; i++) begin
            blk[i]    = w;
            exp_el[i] = 8'h00;
        end
    endtask

    task automatic send_words(input string tag, input int n, input int gap);
        int   sent  = 0;
        int   guard = 0;
        logic rdy;
        while (sent < n && guard < 4000) begin
            i_float32 = blk[sent];
            i_valid   = 1'b1;
            rdy       = o_ready;
            tick();
            guard++;
            if (rdy) sent++;
            i_valid = 1'b0;
            for (int g = 0; g < gap && sent < n; g++) tick();
        end
        check_eq({tag, "_accepts"}, 32'(sent), 32'(n));
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (o_valid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_block(input string tag, input logic [7:0] scale, input logic sat, input logic nan);
        check_eq({tag, "_valid"}, 32'(o_valid), 32'd1);
        check_eq({tag, "_ready"}, 32'(o_ready), 32'd0);
        check_eq({tag, "_scale"}, 32'(o_scale), 32'(scale));
        check_eq({tag, "_sat"},   32'(o_saturated), 32'(sat));
        check_eq({tag, "_nan"},   32'(o_is_nan), 32'(nan));
        for (int i = 0; i < BS; i++)
            check_eq($sformatf("%s_el%0d", tag, i), 32'(o_mxint8_elements[i]), 32'(exp_el[i]));
    endtask

    task automatic handshake(input string tag);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_eq({tag, "_hs_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_hs_ready"}, 32'(o_ready), 32'd1);
        check_eq({tag, "_hs_sat"},   32'(o_saturated), 32'd0);
    endtask

    task automatic one_block_1p0(input string tag);
        fill(32'h3F800000);
        for (int i = 0; i < BS; i++) exp_el[i] = 8'h40;
        send_words(tag, BS, 0);
        wait_valid(edges);
        check_eq({tag, "_latency"}, 32'(edges), 32'(BS + 1));
        check_block(tag, 8'h7F, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_float32 = '0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();

        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        check_eq("rst_scale", 32'(o_scale), 32'd0);
        check_eq("rst_elems", 32'(o_mxint8_elements[0]) | 32'(o_mxint8_elements[BS-1]), 32'd0);
        check_eq("rst_sat",   32'(o_saturated), 32'd0);
        check_eq("rst_nan",   32'(o_is_nan), 32'd0);

        // 1: uniform 1.0
        one_block_1p0("t1");
        handshake("t1");

        // 2: 2.0 sets scale 0x80, 0.75 -> 0x18
        fill(32'h00000000);
        blk[0] = 32'h40000000; exp_el[0] = 8'h40;
        blk[1] = 32'h3F400000; exp_el[1] = 8'h18;
        send_words("t2", BS, 0);
        wait_valid(edges);
        check_block("t2", 8'h80, 1'b0, 1'b0);
        handshake("t2");

        // 3: rounding past 127 clamps; negative element
        fill(32'h00000000);
        blk[0] = 32'h3FFFFFFF; exp_el[0] = 8'h7F;
        blk[1] = 32'hBF800000; exp_el[1] = 8'hC0;
        send_words("t3", BS, 0);
        wait_valid(edges);
        check_block("t3", 8'h7F, 1'b1, 1'b0);
        handshake("t3");

        // 4: a NaN poisons the block
        fill(32'h3F800000);
        blk[5] = 32'h7FC00000;
        send_words("t4", BS, 0);
        wait_valid(edges);
        check_block("t4", 8'hFF, 1'b0, 1'b1);
        handshake("t4");

        // 5: zeros/subnormals with input gaps
        fill(32'h00000000);
        for (int i = 1; i < BS; i += 2) blk[i] = 32'h00000001;
        send_words("t5", BS, 3);
        wait_valid(edges);
        check_eq("t5_latency", 32'(edges), 32'(BS + 1));
        check_block("t5", 8'h00, 1'b0, 1'b0);
        handshake("t5");

        // 6: back-pressure hold, then reset mid-collect
        one_block_1p0("t6a");
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("t6_hold%0d_valid", c), 32'(o_valid), 32'd1);
            check_eq($sformatf("t6_hold%0d_ready", c), 32'(o_ready), 32'd0);
            check_eq($sformatf("t6_hold%0d_scale", c), 32'(o_scale), 32'h7F);
            check_eq($sformatf("t6_hold%0d_el7", c), 32'(o_mxint8_elements[7]), 32'h40);
        end
        handshake("t6a");
        fill(32'h40000000);
        send_words("t6_partial", 10, 0);
        i_rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(o_valid), 32'd0);
        check_eq("t6_rst_ready", 32'(o_ready), 32'd1);
        tick();
        i_rst = 1'b0;
        tick();
        one_block_1p0("t6b");
        handshake("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
